// File: rtl/aes128_key_sched_seq_if.sv
// Key-load / round-key-read bus of the iterative AES-128 key schedule.
// master: key source and inverse-cipher datapath; slave: the key schedule block.
interface aes128_key_sched_seq_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         sched_valid;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_out_valid;
    logic         rk_rd_err;

    modport master (
        output key_in, key_valid, rk_rd_en, rk_idx,
        input  key_ready, busy, sched_valid, rk_out, rk_out_valid, rk_rd_err
    );

    modport slave (
        input  key_in, key_valid, rk_rd_en, rk_idx,
        output key_ready, busy, sched_valid, rk_out, rk_out_valid, rk_rd_err
    );
endinterface

// File: rtl/aes128_key_sched_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// store, read back by index (decrypt order by default).
// Optional macro AES_KS_ZEROIZE_EN adds a zeroize input that clears the store
// and rk_out; without it the store survives rst and only control is reset.
module aes128_key_sched_seq #(
    parameter int DEC_ORDER = 1,
    parameter int RD_LAT    = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef AES_KS_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes128_key_sched_seq_if.slave bus
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("aes128_key_sched_seq: only RD_LAT = 1 is supported");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        state_q;
    logic [3:0]    rcnt_q;
    logic [127:0]  rk_prev_q;
    logic [127:0]  rk_q [0:10];
    logic [127:0]  rk_out_q;
    logic          rk_out_valid_q, rk_rd_err_q;
    logic          key_ready_q, busy_q, sched_valid_q;

    logic          clear, accept, expanding, rd_ok;
    logic [3:0]    rd_idx;
    logic [127:0]  rd_data, rk_next_d;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef AES_KS_ZEROIZE_EN
    assign clear = rst | zeroize;
`else
    assign clear = rst;
`endif

    assign accept    = bus.key_valid & key_ready_q & (state_q != EXPAND) & ~clear;
    assign expanding = (state_q == EXPAND) & ~clear;
    assign rd_ok     = bus.rk_rd_en & sched_valid_q & (bus.rk_idx <= 4'd10);
    assign rd_idx    = (DEC_ORDER != 0) ? 4'd10 - bus.rk_idx : bus.rk_idx;

    // One FIPS-197 round of the expansion applied to the previous round key.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, t;
        w0 = rk_prev_q[127:96];
        w1 = rk_prev_q[95:64];
        w2 = rk_prev_q[63:32];
        w3 = rk_prev_q[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(rcnt_q), 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        rk_next_d = {w0, w1, w2, w3};
    end

    // Read mux over the round-key store.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i <= 10; i++) begin
            if (rd_idx == 4'(i)) rd_data = rk_q[i];
        end
    end

    // Round-key store: written on key accept and once per expansion cycle.
    always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
        if (clear) begin
            for (int unsigned i = 0; i <= 10; i++) rk_q[i] <= '0;
        end else
`endif
        begin
            if (accept) rk_q[0] <= bus.key_in;
            if (expanding) begin
                for (int unsigned i = 1; i <= 10; i++) begin
                    if (rcnt_q == 4'(i)) rk_q[i] <= rk_next_d;
                end
            end
        end
    end

    // Control FSM with registered status outputs and the registered read port;
    // a read coinciding with a key accept sees the old store and old sched_valid.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q        <= IDLE;
            rcnt_q         <= '0;
            rk_prev_q      <= '0;
            key_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            sched_valid_q  <= 1'b0;
            rk_out_q       <= '0;
            rk_out_valid_q <= 1'b0;
            rk_rd_err_q    <= 1'b0;
        end else begin
            rk_out_valid_q <= rd_ok;
            rk_rd_err_q    <= bus.rk_rd_en & ~rd_ok;
            if (rd_ok) rk_out_q <= rd_data;
            case (state_q)
                IDLE, READY: begin
                    if (accept) begin
                        state_q       <= EXPAND;
                        rcnt_q        <= 4'd1;
                        rk_prev_q     <= bus.key_in;
                        key_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        sched_valid_q <= 1'b0;
                    end else begin
                        key_ready_q   <= 1'b1;
                    end
                end
                EXPAND: begin
                    rk_prev_q <= rk_next_d;
                    if (rcnt_q == 4'd10) begin
                        state_q       <= READY;
                        busy_q        <= 1'b0;
                        sched_valid_q <= 1'b1;
                        key_ready_q   <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.key_ready    = key_ready_q;
    assign bus.busy         = busy_q;
    assign bus.sched_valid  = sched_valid_q;
    assign bus.rk_out       = rk_out_q;
    assign bus.rk_out_valid = rk_out_valid_q;
    assign bus.rk_rd_err    = rk_rd_err_q;

endmodule

// File: tb/tb_aes128_key_sched_seq.sv
// Directed bench for aes128_key_sched_seq (default build, DEC_ORDER = 1).
module tb_aes128_key_sched_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes128_key_sched_seq_if bus();

    aes128_key_sched_seq #(.DEC_ORDER(1), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         err;
        logic [127:0] data;
    } rd_exp_t;

    rd_exp_t      sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [127:0] exp_rk_out = '0;
    logic [127:0] a1_rk [0:10];
    logic [127:0] key_a1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] key_alt  = 128'hffeeddccbbaa99887766554433221100;
    logic [127:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one read; the scoreboard entry is pushed at issue and checked next cycle.
    task automatic rd(input logic [3:0] idx, input logic ok, input logic [127:0] data, input string tag);
        rd_exp_t e;
        bus.rk_rd_en = 1'b1;
        bus.rk_idx   = idx;
        if (ok) exp_rk_out = data;
        e.valid = ok;
        e.err   = ~ok;
        e.data  = exp_rk_out;
        sb.push_back(e);
        step();
        bus.rk_rd_en = 1'b0;
        chk_rd(tag);
    endtask

    task automatic chk_rd(input string tag);
        rd_exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 128'(bus.rk_out_valid), 128'(e.valid));
            chk({tag, "_err"},   128'(bus.rk_rd_err),    128'(e.err));
            chk({tag, "_data"},  bus.rk_out,             e.data);
        end
    endtask

    task automatic chk_status(input string tag, input logic kr, input logic bz, input logic sv);
        chk({tag, "_key_ready"},   128'(bus.key_ready),   128'(kr));
        chk({tag, "_busy"},        128'(bus.busy),        128'(bz));
        chk({tag, "_sched_valid"}, 128'(bus.sched_valid), 128'(sv));
    endtask

    initial begin
        a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_rd_en  = 1'b0;
        bus.rk_idx    = '0;

        // Reset values
        step();
        step();
        chk_status("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_rk_out", bus.rk_out, '0);
        chk("rst_rk_out_valid", 128'(bus.rk_out_valid), '0);
        chk("rst_rk_rd_err", 128'(bus.rk_rd_err), '0);
        rst = 1'b0;
        step();
        chk_status("idle", 1'b1, 1'b0, 1'b0);

        // FIPS-197 A.1 key; a different key held valid during EXPAND must be ignored
        bus.key_in    = key_a1;
        bus.key_valid = 1'b1;
        step();
        bus.key_in = key_alt;
        chk_status("acc1", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("exp1_c%0d_sv", i), 128'(bus.sched_valid), '0);
        end
        bus.key_valid = 1'b0;
        step();
        chk_status("ready1", 1'b1, 1'b0, 1'b1);

        // Decrypt-order reads, back to back
        for (int i = 0; i <= 10; i++) begin
            rd(4'(i), 1'b1, a1_rk[10 - i], $sformatf("a1_idx%0d", i));
        end

        // Out-of-range indices
        rd(4'd11, 1'b0, '0, "idx11");
        rd(4'd15, 1'b0, '0, "idx15");
        step();
        chk("idle_rd_valid", 128'(bus.rk_out_valid), '0);
        chk("idle_rd_err", 128'(bus.rk_rd_err), '0);
        chk("idle_rd_hold", bus.rk_out, exp_rk_out);

        // Re-key with zeros together with a read of idx 0 from the old schedule
        rd(4'd0, 1'b1, a1_rk[10], "idx0");
        bus.key_in    = '0;
        bus.key_valid = 1'b1;
        rd(4'd0, 1'b1, a1_rk[10], "rekey_rd");
        bus.key_valid = 1'b0;
        chk_status("acc2", 1'b0, 1'b1, 1'b0);
        rd(4'd0, 1'b0, '0, "exp2_rd");
        for (int i = 2; i <= 9; i++) begin
            step();
            chk($sformatf("exp2_c%0d_sv", i), 128'(bus.sched_valid), '0);
        end
        step();
        chk_status("ready2", 1'b1, 1'b0, 1'b1);
        rd(4'd0, 1'b1, zero_rk10, "zero_idx0");

        // Reset in the middle of expansion
        bus.key_in    = key_a1;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        chk("mid_busy", 128'(bus.busy), 128'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_rk_out = '0;
        chk_status("midrst", 1'b0, 1'b0, 1'b0);
        chk("midrst_rk_out", bus.rk_out, '0);
        step();
        chk_status("midrst_idle", 1'b1, 1'b0, 1'b0);
        rd(4'd3, 1'b0, '0, "midrst_rd");
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("midrst_c%0d_sv", i), 128'(bus.sched_valid), '0);
        end

        // Re-key after the aborted expansion
        bus.key_in    = key_a1;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        chk_status("ready3", 1'b1, 1'b0, 1'b1);
        rd(4'd0, 1'b1, a1_rk[10], "rk3_idx0");
        rd(4'd5, 1'b1, a1_rk[5],  "rk3_idx5");
        rd(4'd12, 1'b0, '0,       "rk3_idx12");

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
